i2c_shift_engine: RTL and testbench

//   Parametrised bidirectional serialiser/deserialiser for the I2C master datapath.
//   TX mode: loads a WIDTH-bit word in parallel and shifts it onto SDA.
//   RX mode: samples SDA into a WIDTH-bit word.

---
 rtl/i2c_shift_engine_if.sv | 24 ++
 rtl/i2c_shift_engine.sv | 90 +++++++++
 tb/tb_i2c_shift_engine.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/i2c_shift_engine_if.sv
// i2c_shift_engine_if: load handshake, bit strobe and serial/parallel data bundle for the I2C shift engine.
interface i2c_shift_engine_if #(parameter int WIDTH = 8);
  localparam int CNT_W = $clog2(WIDTH + 1);
  logic             load_valid;
  logic             load_ready;
  logic             mode;
  logic [WIDTH-1:0] data_in;
  logic             shift_en;
  logic             abort;
  logic             sda_in;
  logic             sda_out;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] bit_cnt;
  modport master (
    output load_valid, mode, data_in, shift_en, abort, sda_in,
    input  load_ready, sda_out, data_out, busy, done, bit_cnt
  );
  modport slave (
    input  load_valid, mode, data_in, shift_en, abort, sda_in,
    output load_ready, sda_out, data_out, busy, done, bit_cnt
  );
endinterface

// File: rtl/i2c_shift_engine.sv
// i2c_shift_engine: strobe-paced TX serialiser / RX deserialiser for the I2C master datapath.
module i2c_shift_engine #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  i2c_shift_engine_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sda_q, sda_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] tx_next, rx_next;
  logic             first_bit, next_bit, last;
  assign tx_next   = MSB_FIRST ? shreg_q << 1 : shreg_q >> 1;
  assign rx_next   = MSB_FIRST ? {shreg_q[WIDTH-2:0], bus.sda_in} : {bus.sda_in, shreg_q[WIDTH-1:1]};
  assign first_bit = MSB_FIRST ? bus.data_in[WIDTH-1] : bus.data_in[0];
  assign next_bit  = MSB_FIRST ? shreg_q[WIDTH-2] : shreg_q[1];
  assign last      = cnt_q == CNT_W'(WIDTH - 1);
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    sda_d   = sda_q;
    dout_d  = dout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (bus.load_valid) begin
        state_d = SHIFT;
        mode_d  = bus.mode;
        cnt_d   = '0;
        busy_d  = 1'b1;
        shreg_d = bus.mode ? '0 : bus.data_in;
        sda_d   = bus.mode | first_bit;
      end
    end else if (bus.abort) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      sda_d   = 1'b1;
      cnt_d   = '0;
    end else if (bus.shift_en) begin
      cnt_d   = cnt_q + 1'b1;
      shreg_d = mode_q ? rx_next : tx_next;
      sda_d   = mode_q | next_bit;
      if (last) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        sda_d   = 1'b1;
        dout_d  = mode_q ? rx_next : dout_q;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      shreg_q <= '0;
      cnt_q   <= '0;
      sda_q   <= 1'b1;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      sda_q   <= sda_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign bus.load_ready = state_q == IDLE;
  assign bus.sda_out    = sda_q;
  assign bus.data_out   = dout_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.bit_cnt    = cnt_q;
endmodule

// File: tb/tb_i2c_shift_engine.sv
// tb_i2c_shift_engine: MSB-first and LSB-first engines driven in lockstep from one vector table plus corner sequences.
module tb_i2c_shift_engine;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  typedef struct {
    logic       lv, md;
    logic [7:0] din;
    logic       se, ab, si;
    logic       sa, sb, bsy, dn, rdy;
    logic [3:0] cnt;
    logic [7:0] da, db;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vt[$];
  always #5 clk = ~clk;
  i2c_shift_engine_if #(.WIDTH(8)) ia ();
  i2c_shift_engine_if #(.WIDTH(8)) ib ();
  assign ib.load_valid = ia.load_valid;
  assign ib.mode       = ia.mode;
  assign ib.data_in    = ia.data_in;
  assign ib.shift_en   = ia.shift_en;
  assign ib.abort      = ia.abort;
  assign ib.sda_in     = ia.sda_in;
  i2c_shift_engine #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  i2c_shift_engine #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));
  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic lv, md, input logic [7:0] din, input logic se, ab, si);
    ia.load_valid = lv;
    ia.mode       = md;
    ia.data_in    = din;
    ia.shift_en   = se;
    ia.abort      = ab;
    ia.sda_in     = si;
  endtask
  function automatic void add(input logic lv, md, input logic [7:0] din, input logic se, ab, si,
                              input logic sa, sb, bsy, dn, rdy, input logic [3:0] cnt,
                              input logic [7:0] da, db);
    vt.push_back('{lv, md, din, se, ab, si, sa, sb, bsy, dn, rdy, cnt, da, db});
  endfunction
  initial begin
    drive(L, L, 8'h00, L, L, L);
    // TX 0xC5: MSB order 1,1,0,0,0,1,0,1 on dut_a, LSB order 1,0,1,0,0,0,1,1 on dut_b
    add(H, L, 8'hC5, L, L, L, H, H, H, L, L, 4'd0, 8'h00, 8'h00);
    add(L, L, 8'h00, H, L, L, H, L, H, L, L, 4'd1, 8'h00, 8'h00);
    add(L, L, 8'h00, H, L, L, L, H, H, L, L, 4'd2, 8'h00, 8'h00);
    add(L, L, 8'h00, H, L, L, L, L, H, L, L, 4'd3, 8'h00, 8'h00);
    add(L, L, 8'h00, L, L, L, L, L, H, L, L, 4'd3, 8'h00, 8'h00);
    add(L, L, 8'h00, H, L, L, L, L, H, L, L, 4'd4, 8'h00, 8'h00);
    add(L, L, 8'h00, H, L, L, H, L, H, L, L, 4'd5, 8'h00, 8'h00);
    add(L, L, 8'h00, H, L, L, L, H, H, L, L, 4'd6, 8'h00, 8'h00);
    add(L, L, 8'h00, H, L, L, H, H, H, L, L, 4'd7, 8'h00, 8'h00);
    add(L, L, 8'h00, H, L, L, H, H, L, H, H, 4'd8, 8'h00, 8'h00);
    add(L, L, 8'h00, L, L, L, H, H, L, L, H, 4'd8, 8'h00, 8'h00);
    add(L, L, 8'h00, H, L, L, H, H, L, L, H, 4'd8, 8'h00, 8'h00);
    // RX 1,0,0,1,1,0,1,0 -> 0x9A MSB-first, 0x59 LSB-first; Mode and Load_valid ignored mid-word
    add(H, H, 8'hFF, L, L, L, H, H, H, L, L, 4'd0, 8'h00, 8'h00);
    add(L, L, 8'h00, H, L, H, H, H, H, L, L, 4'd1, 8'h00, 8'h00);
    add(L, L, 8'h00, H, L, L, H, H, H, L, L, 4'd2, 8'h00, 8'h00);
    add(L, L, 8'h00, H, L, L, H, H, H, L, L, 4'd3, 8'h00, 8'h00);
    add(H, L, 8'h55, H, L, H, H, H, H, L, L, 4'd4, 8'h00, 8'h00);
    add(L, L, 8'h00, H, L, H, H, H, H, L, L, 4'd5, 8'h00, 8'h00);
    add(L, L, 8'h00, H, L, L, H, H, H, L, L, 4'd6, 8'h00, 8'h00);
    add(L, L, 8'h00, H, L, H, H, H, H, L, L, 4'd7, 8'h00, 8'h00);
    add(L, L, 8'h00, H, L, L, H, H, L, H, H, 4'd8, 8'h9A, 8'h59);
    add(L, L, 8'h00, L, L, L, H, H, L, L, H, 4'd8, 8'h9A, 8'h59);
    // TX 0xFF aborted after 3 strobes, abort beating a coincident strobe
    add(H, L, 8'hFF, L, L, L, H, H, H, L, L, 4'd0, 8'h9A, 8'h59);
    add(L, L, 8'h00, H, L, L, H, H, H, L, L, 4'd1, 8'h9A, 8'h59);
    add(L, L, 8'h00, H, L, L, H, H, H, L, L, 4'd2, 8'h9A, 8'h59);
    add(L, L, 8'h00, H, L, L, H, H, H, L, L, 4'd3, 8'h9A, 8'h59);
    add(L, L, 8'h00, H, H, L, H, H, L, L, H, 4'd0, 8'h9A, 8'h59);
    add(L, L, 8'h00, L, L, L, H, H, L, L, H, 4'd0, 8'h9A, 8'h59);
    // abort coinciding with a load in IDLE: load wins
    add(H, L, 8'h00, L, H, L, L, L, H, L, L, 4'd0, 8'h9A, 8'h59);
    add(L, L, 8'h00, L, H, L, H, H, L, L, H, 4'd0, 8'h9A, 8'h59);
    add(L, L, 8'h00, L, L, L, H, H, L, L, H, 4'd0, 8'h9A, 8'h59);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("rst_rdy", 0, 32'(ia.load_ready), 32'd1);
    chk("rst_busy", 0, 32'(ia.busy), 32'd0);
    chk("rst_done", 0, 32'(ia.done), 32'd0);
    chk("rst_sda", 0, 32'(ia.sda_out), 32'd1);
    chk("rst_cnt", 0, 32'(ia.bit_cnt), 32'd0);
    chk("rst_dout", 0, 32'(ia.data_out), 32'd0);
    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].lv, vt[i].md, vt[i].din, vt[i].se, vt[i].ab, vt[i].si);
      step();
      chk("sda_a", i, 32'(ia.sda_out), 32'(vt[i].sa));
      chk("sda_b", i, 32'(ib.sda_out), 32'(vt[i].sb));
      chk("busy", i, 32'(ia.busy), 32'(vt[i].bsy));
      chk("done_a", i, 32'(ia.done), 32'(vt[i].dn));
      chk("done_b", i, 32'(ib.done), 32'(vt[i].dn));
      chk("ready", i, 32'(ia.load_ready), 32'(vt[i].rdy));
      chk("cnt", i, 32'(ia.bit_cnt), 32'(vt[i].cnt));
      chk("dout_a", i, 32'(ia.data_out), 32'(vt[i].da));
      chk("dout_b", i, 32'(ib.data_out), 32'(vt[i].db));
    end
    // back-to-back: load 0x3C in the Done cycle with Shift_en tied high
    drive(H, L, 8'h81, H, L, L);
    step();
    chk("b2b_busy1", 0, 32'(ia.busy), 32'd1);
    ia.load_valid = L;
    repeat (7) step();
    chk("b2b_cnt7", 0, 32'(ia.bit_cnt), 32'd7);
    chk("b2b_nodone7", 0, 32'(ia.done), 32'd0);
    step();
    chk("b2b_done1", 0, 32'(ia.done), 32'd1);
    chk("b2b_rdy", 0, 32'(ia.load_ready), 32'd1);
    ia.load_valid = H;
    ia.data_in    = 8'h3C;
    step();
    chk("b2b_done_drop", 0, 32'(ia.done), 32'd0);
    chk("b2b_busy2", 0, 32'(ia.busy), 32'd1);
    chk("b2b_cnt0", 0, 32'(ia.bit_cnt), 32'd0);
    chk("b2b_sda_a0", 0, 32'(ia.sda_out), 32'd0);
    chk("b2b_sda_b0", 0, 32'(ib.sda_out), 32'd0);
    ia.load_valid = L;
    repeat (2) step();
    chk("b2b_sda_a2", 0, 32'(ia.sda_out), 32'd1);
    chk("b2b_sda_b2", 0, 32'(ib.sda_out), 32'd1);
    repeat (5) step();
    chk("b2b_cnt7b", 0, 32'(ia.bit_cnt), 32'd7);
    chk("b2b_nodone7b", 0, 32'(ia.done), 32'd0);
    chk("b2b_sda_a7", 0, 32'(ia.sda_out), 32'd0);
    step();
    chk("b2b_done2", 0, 32'(ia.done), 32'd1);
    chk("b2b_cnt8", 0, 32'(ia.bit_cnt), 32'd8);
    chk("b2b_sda_rel", 0, 32'(ia.sda_out), 32'd1);
    ia.shift_en = L;
    step();
    chk("b2b_done_end", 0, 32'(ia.done), 32'd0);
    // asynchronous reset in the middle of an RX word
    drive(H, H, 8'h00, L, L, L);
    step();
    drive(L, L, 8'h00, H, L, H);
    repeat (4) step();
    chk("rx_cnt4", 0, 32'(ia.bit_cnt), 32'd4);
    chk("rx_busy", 0, 32'(ia.busy), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", 0, 32'(ia.busy), 32'd0);
    chk("arst_done", 0, 32'(ia.done), 32'd0);
    chk("arst_sda", 0, 32'(ia.sda_out), 32'd1);
    chk("arst_cnt", 0, 32'(ia.bit_cnt), 32'd0);
    chk("arst_dout_a", 0, 32'(ia.data_out), 32'd0);
    chk("arst_dout_b", 0, 32'(ib.data_out), 32'd0);
    repeat (2) step();
    chk("arst_hold_done", 0, 32'(ia.done), 32'd0);
    rst_n = 1'b1;
    ia.shift_en = L;
    step();
    chk("arst_rdy", 0, 32'(ia.load_ready), 32'd1);
    chk("arst_post_done", 0, 32'(ia.done), 32'd0);
    chk("arst_post_busy", 0, 32'(ia.busy), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
